// File: rtl/stream_roller_if.sv
// stream_roller_if: handshake bundle for the stream_roller width-down serialiser.
// Carries the NUM-element input vector side and the ROLL_NUM-element output
// beat side. The slave modport is the serialiser's view; the master modport is
// the view of the surrounding datapath (vector source plus beat sink).
// Optional feature macro: STREAM_ROLLER_VAR_LEN_EN adds data_in_count.
interface stream_roller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int ROLL_NUM   = 3
);
`ifdef STREAM_ROLLER_VAR_LEN_EN
  localparam int CW = $clog2(NUM + 1);
  logic [CW-1:0]                       data_in_count;
`endif
  logic [NUM-1:0][DATA_WIDTH-1:0]      data_in;
  logic                                data_in_valid;
  logic                                data_in_ready;
  logic [ROLL_NUM-1:0][DATA_WIDTH-1:0] data_out;
  logic [ROLL_NUM-1:0]                 data_out_keep;
  logic                                data_out_last;
  logic                                data_out_valid;
  logic                                data_out_ready;

`ifdef STREAM_ROLLER_VAR_LEN_EN
  modport slave (
    input  data_in, data_in_count, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_keep, data_out_last, data_out_valid
  );
  modport master (
    output data_in, data_in_count, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_keep, data_out_last, data_out_valid
  );
`else
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_keep, data_out_last, data_out_valid
  );
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_keep, data_out_last, data_out_valid
  );
`endif
endinterface

// File: rtl/stream_roller.sv
// stream_roller: width-down serialiser. Accepts one NUM-element vector per
// input handshake and emits it as ROLL_NUM-element beats, element 0 first,
// with keep/last side-band for a partial final beat. A new vector may be
// accepted in the same cycle the last beat leaves, so vectors stream with no
// bubble. All output side-band is decoded from registers only.
// Optional feature macro: STREAM_ROLLER_VAR_LEN_EN enables a per-vector
// element count (clamped to NUM; a count of zero is accepted and dropped).
module stream_roller #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int ROLL_NUM   = 3
) (
  input  logic           clk,
  input  logic           rst,
  stream_roller_if.slave bus
);

  localparam int BEATS = (NUM + ROLL_NUM - 1) / ROLL_NUM;
  localparam int CW    = $clog2(NUM + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Element-index width: must hold BEATS*ROLL_NUM, the first index past the
  // final beat, which can exceed NUM when the last beat is partial.
  localparam int IW    = $clog2(NUM + ROLL_NUM + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [NUM-1:0][DATA_WIDTH-1:0]      vec_r;
  logic [CW-1:0]                       len_r;
  logic [BW-1:0]                       beat_r;
  logic [0:0]                          state_r;

  logic [CW-1:0]                       count_s;
  logic [IW-1:0]                       base_s;
  logic                                valid_s;
  logic                                last_s;
  logic                                in_ready_s;
  logic                                accept_s;
  logic                                out_fire_s;
  logic [ROLL_NUM-1:0][DATA_WIDTH-1:0] data_s;
  logic [ROLL_NUM-1:0]                 keep_s;

  // Length of the vector being offered: runtime count clamped to NUM, or NUM.
  always_comb begin
    count_s = CW'(NUM);
`ifdef STREAM_ROLLER_VAR_LEN_EN
    if (bus.data_in_count > CW'(NUM)) begin
      count_s = CW'(NUM);
    end else begin
      count_s = bus.data_in_count;
    end
`endif
  end

  // Handshake decode. The last beat is the one whose lanes reach len; this
  // avoids dividing len by ROLL_NUM to find the beat count.
  always_comb begin
    valid_s    = (state_r == ST_BUSY);
    base_s     = IW'(beat_r) * IW'(ROLL_NUM);
    last_s     = valid_s && ((base_s + IW'(ROLL_NUM)) >= IW'(len_r));
    in_ready_s = !rst && (!valid_s || (last_s && bus.data_out_ready));
    accept_s   = bus.data_in_valid && in_ready_s;
    out_fire_s = valid_s && bus.data_out_ready;
  end

  // Lane selection: each lane picks element base+lane when it lies inside len,
  // otherwise the lane is zero with keep low.
  always_comb begin
    for (int i = 0; i < ROLL_NUM; i++) begin
      logic [IW-1:0]         idx_v;
      logic [DATA_WIDTH-1:0] sel_v;
      idx_v = base_s + IW'(i);
      sel_v = {DATA_WIDTH{1'b0}};
      for (int j = 0; j < NUM; j++) begin
        sel_v = sel_v | ((idx_v == IW'(j)) ? vec_r[j] : {DATA_WIDTH{1'b0}});
      end
      keep_s[i] = valid_s && (idx_v < IW'(len_r));
      data_s[i] = keep_s[i] ? sel_v : {DATA_WIDTH{1'b0}};
    end
  end

  assign bus.data_in_ready  = in_ready_s;
  assign bus.data_out       = data_s;
  assign bus.data_out_keep  = keep_s;
  assign bus.data_out_last  = last_s;
  assign bus.data_out_valid = valid_s;

  // Vector storage and beat sequencing; an accept takes priority because it
  // can only coincide with the final beat leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r   <= {(NUM*DATA_WIDTH){1'b0}};
      len_r   <= {CW{1'b0}};
      beat_r  <= {BW{1'b0}};
      state_r <= ST_IDLE;
    end else if (accept_s) begin
      vec_r   <= bus.data_in;
      len_r   <= count_s;
      beat_r  <= {BW{1'b0}};
      state_r <= (count_s != {CW{1'b0}}) ? ST_BUSY : ST_IDLE;
    end else if (out_fire_s) begin
      if (last_s) begin
        beat_r  <= {BW{1'b0}};
        state_r <= ST_IDLE;
      end else begin
        beat_r  <= beat_r + BW'(1);
        state_r <= state_r;
      end
    end else begin
      beat_r  <= beat_r;
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_stream_roller.sv
// tb_stream_roller: randomized self-checking bench for stream_roller.
// Main instance NUM=8/ROLL_NUM=3 is compared every cycle against a queue of
// expected beats built from each accepted vector. Two small instances
// (6/2 and 5/5) get a directed vector each.
// Honours STREAM_ROLLER_VAR_LEN_EN when it is defined for the build.
module tb_stream_roller;

  localparam int DW = 16;
  localparam int NA = 8;
  localparam int RA = 3;

  typedef struct {
    logic [RA-1:0][DW-1:0] d;
    logic [RA-1:0]         keep;
    logic                  last;
  } beat_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  stream_roller_if #(.DATA_WIDTH(DW), .NUM(NA), .ROLL_NUM(RA)) bus_a ();
  stream_roller_if #(.DATA_WIDTH(DW), .NUM(6),  .ROLL_NUM(2))  bus_b ();
  stream_roller_if #(.DATA_WIDTH(DW), .NUM(5),  .ROLL_NUM(5))  bus_c ();

  stream_roller #(.DATA_WIDTH(DW), .NUM(NA), .ROLL_NUM(RA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  stream_roller #(.DATA_WIDTH(DW), .NUM(6),  .ROLL_NUM(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  stream_roller #(.DATA_WIDTH(DW), .NUM(5),  .ROLL_NUM(5))  dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  beat_t                 exp_q[$];
  logic [NA-1:0][DW-1:0] cur_vec;
  int                    cur_cnt;
  int                    vec_no;

  // Reference: split a vector of len elements into ceil(len/RA) beats.
  task automatic push_vec(input logic [NA-1:0][DW-1:0] v, input int cnt);
    int len;
    int nb;
    beat_t b;
    len = (cnt > NA) ? NA : cnt;
    nb  = (len + RA - 1) / RA;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < RA; i++) begin
        if (k * RA + i < len) begin
          b.d[i]    = v[k * RA + i];
          b.keep[i] = 1'b1;
        end else begin
          b.d[i]    = '0;
          b.keep[i] = 1'b0;
        end
      end
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic new_offer();
    for (int i = 0; i < NA; i++) begin
      cur_vec[i] = (vec_no <= 3) ? DW'(i + 1) : DW'($urandom);
    end
    cur_cnt = NA;
`ifdef STREAM_ROLLER_VAR_LEN_EN
    case (vec_no)
      0:       cur_cnt = NA;
      1:       cur_cnt = 4;
      2:       cur_cnt = 0;
      3:       cur_cnt = 9;
      default: cur_cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, NA));
    endcase
`endif
  endtask

  initial begin
    logic exp_ready;
    logic acc;
    logic fire;
    logic done_rst;
    logic after_rst;
    logic [5:0][DW-1:0] vb;
    logic [4:0][DW-1:0] vc;
    logic [1:0][DW-1:0] eb;

    n_checks  = 0;
    n_errors  = 0;
    vec_no    = 0;
    done_rst  = 1'b0;
    after_rst = 1'b0;
    rst       = 1'b1;
    bus_a.data_in = '0; bus_a.data_in_valid = 1'b0; bus_a.data_out_ready = 1'b0;
    bus_b.data_in = '0; bus_b.data_in_valid = 1'b0; bus_b.data_out_ready = 1'b1;
    bus_c.data_in = '0; bus_c.data_in_valid = 1'b0; bus_c.data_out_ready = 1'b1;
`ifdef STREAM_ROLLER_VAR_LEN_EN
    bus_a.data_in_count = 4'd8;
    bus_b.data_in_count = 3'd6;
    bus_c.data_in_count = 3'd5;
`endif
    new_offer();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus_a.data_out_valid, 1'b0);
    check("rst_last",  bus_a.data_out_last,  1'b0);
    check("rst_keep",  bus_a.data_out_keep,  3'b000);
    check("rst_data",  bus_a.data_out,       48'h0);
    check("rst_ready", bus_a.data_in_ready,  1'b0);
    @(posedge clk);
    #1;

    // Main randomized run against the beat queue
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = 1'b0;
      if (!done_rst && cyc >= 150 && exp_q.size() == 2) begin
        rst      = 1'b1;
        done_rst = 1'b1;
      end
      bus_a.data_in_valid  = (cyc < 8) ? 1'b1 : logic'($urandom_range(0, 9) < 7);
      bus_a.data_out_ready = (cyc < 8) ? 1'b1 : logic'($urandom_range(0, 9) < 6);
      bus_a.data_in        = cur_vec;
`ifdef STREAM_ROLLER_VAR_LEN_EN
      bus_a.data_in_count  = 4'(cur_cnt);
`endif
      @(negedge clk);
      exp_ready = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && bus_a.data_out_ready));
      check("in_ready", bus_a.data_in_ready, exp_ready);
      check("valid", bus_a.data_out_valid, exp_q.size() != 0);
      check("last", bus_a.data_out_last, (exp_q.size() != 0) && exp_q[0].last);
      if (exp_q.size() != 0) begin
        check("data", bus_a.data_out, exp_q[0].d);
        check("keep", bus_a.data_out_keep, exp_q[0].keep);
      end else if (after_rst) begin
        check("post_rst_data", bus_a.data_out, 48'h0);
        check("post_rst_keep", bus_a.data_out_keep, 3'b000);
      end
      acc  = bus_a.data_in_valid && exp_ready;
      fire = (exp_q.size() != 0) && bus_a.data_out_ready;
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        after_rst = 1'b1;
      end else begin
        after_rst = 1'b0;
        if (fire) void'(exp_q.pop_front());
        if (acc) begin
          push_vec(cur_vec, cur_cnt);
          vec_no++;
          new_offer();
        end
      end
      #1;
    end
    rst = 1'b0;
    bus_a.data_in_valid = 1'b0;
    check("mid_rst_seen", done_rst, 1'b1);

    // NUM=6, ROLL_NUM=2: three full beats
    for (int i = 0; i < 6; i++) vb[i] = DW'($urandom);
    bus_b.data_in = vb;
    bus_b.data_in_valid = 1'b1;
    @(negedge clk);
    check("b_in_ready", bus_b.data_in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus_b.data_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      eb[0] = vb[2 * k];
      eb[1] = vb[2 * k + 1];
      check("b_valid", bus_b.data_out_valid, 1'b1);
      check("b_data",  bus_b.data_out, eb);
      check("b_keep",  bus_b.data_out_keep, 2'b11);
      check("b_last",  bus_b.data_out_last, k == 2);
      @(posedge clk);
    end
    @(negedge clk);
    check("b_idle", bus_b.data_out_valid, 1'b0);
    @(posedge clk);
    #1;

    // NUM=5, ROLL_NUM=5: a single full beat
    for (int i = 0; i < 5; i++) vc[i] = DW'($urandom);
    bus_c.data_in = vc;
    bus_c.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_c.data_in_valid = 1'b0;
    @(negedge clk);
    check("c_valid", bus_c.data_out_valid, 1'b1);
    check("c_data",  bus_c.data_out, vc);
    check("c_keep",  bus_c.data_out_keep, 5'b11111);
    check("c_last",  bus_c.data_out_last, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("c_idle", bus_c.data_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_roller.md
# stream_roller

Parametrised width-down serialiser for the conv datapath. It accepts one NUM-element vector per handshake and emits it as ROLL_NUM-element beats in natural element order, with last/keep side-band for partial final beats. It supports NUM not divisible by ROLL_NUM, back-to-back vectors with no bubble cycle, and an optional per-vector runtime length. It sits between the im2col/window buffers and narrower PE arrays.

## Interface
- DATA_WIDTH, 16, element width in bits
- NUM, 8, elements per input vector (≥1)
- ROLL_NUM, 3, elements per output beat (1 ≤ ROLL_NUM ≤ NUM)
- derived: BEATS = ceil(NUM/ROLL_NUM); CW = $clog2(NUM+1)

- clk  in  1  clock; one clock domain; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- data_in  in  DATA_WIDTH × [NUM]  input vector, element 0 first
- data_in_count  in  CW  valid elements in the vector; present only with STREAM_ROLLER_VAR_LEN_EN
- data_in_valid  in  1  input handshake valid
- data_in_ready  out  1  input handshake ready
- data_out  out  DATA_WIDTH × [ROLL_NUM]  output beat
- data_out_keep  out  ROLL_NUM  per-lane element-valid mask
- data_out_last  out  1  final beat of the current vector
- data_out_valid  out  1  output handshake valid
- data_out_ready  in  1  output handshake ready

## Operation
- Transfer occurs when valid && ready is high at posedge, on either side.
- Storage: one NUM-element register, a beat index `beat` (0..BEATS-1), and a latched length `len`.
- On input accept, the block stores the vector and sets len = the clamped count and beat = 0. data_out_valid is 1 if len > 0.
- Beat k, lane i: data_out[i] = element k·ROLL_NUM+i if that index < len, else 0. data_out_keep[i] = (k·ROLL_NUM+i < len).
- nbeats = ceil(len/ROLL_NUM). data_out_last = data_out_valid && (beat == nbeats-1).
- On output transfer with !last: beat increments. On output transfer with last: the vector is consumed.
- States:
  - IDLE (no valid output): goes to BUSY on accept with len > 0.
  - BUSY, non-last beat: stays in BUSY.
  - BUSY, last beat: goes to IDLE on output transfer if no accept in the same cycle. It reloads and stays in BUSY if an accept occurs in the same cycle.
- data_in_ready = !rst && (!data_out_valid || (data_out_last && data_out_ready)). This is a combinational path from data_out_ready.
- data_out, keep, last and valid derive only from registers. There is no path from data_in to data_out.
- Count handling:
  - count > NUM is clamped to NUM.
  - count == 0 is accepted and dropped. No beats are produced and the block stays IDLE.
- data_out_valid must not drop without a transfer. data_out must be stable while valid && !ready.

## Timing
- Reset state: data_out_valid=0, data_out_last=0, data_out_keep=0, data_out all zeros, beat=0, len=0. data_in_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Latency: if an accept occurs at edge N, beat 0 is valid during cycle N+1.
- Throughput with data_out_ready held high: one beat per cycle. A vector with nbeats beats occupies exactly nbeats cycles, and consecutive vectors have no gap.
- Simultaneous last-beat transfer and input accept: the new vector's beat 0 appears in the next cycle.
- Reset in mid-vector: remaining beats are discarded and the block returns to reset state at the next edge.
- When NUM % ROLL_NUM == 0 and len == NUM, keep is all ones on every beat.

## Configuration
- STREAM_ROLLER_VAR_LEN_EN
  - Defined: the data_in_count port exists, and len is latched from it with clamping and zero-drop as above.
  - Undefined: the data_in_count port is absent and len is fixed at NUM. Beat count is always BEATS. Only the final beat can have a partial keep, and only when NUM % ROLL_NUM != 0.

## Test plan
- NUM=8, ROLL_NUM=3, data_in=1..8, data_out_ready=1 → beats {1,2,3},{4,5,6},{7,8,0}. keep 111,111,011. last is high on the third beat only. valid is high for 3 cycles starting one cycle after the accept.
- Two vectors offered back-to-back with data_out_ready=1 → 6 consecutive valid cycles, no bubble. data_in_ready is high in the cycle of the first last beat.
- Random data_out_ready stalls during the second beat → data_out, keep and last stay stable while stalled. There are no duplicate or skipped beats, and data_in_ready stays low until the last beat transfers.
- With VAR_LEN_EN and count=4 → beats {1,2,3} keep 111, then {4,0,0} keep 001 with last. With count=0, the block stays IDLE with no valid. With count=9, it behaves as count=8.
- rst asserted during beat 1 → the next cycle has valid=0, last=0, keep=0 and data_out all zeros. data_in_ready=1 after rst is released, and a new vector is then accepted and emitted from beat 0.
- NUM=6, ROLL_NUM=2 → 3 beats with keep 11 on every beat. NUM=5, ROLL_NUM=5 → a single beat with last=1 and keep=11111.
